// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Desc     : Shared widths, JALR opcode and fetch state encoding
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          PC_W     = 8;
    localparam int          INST_W   = 32;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    function automatic logic is_jalr(input logic [INST_W-1:0] inst);
        return inst[6:0] == OPC_JALR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid
// Desc     : One-entry skid register holding a stalled fetch response
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_drain,
    input  logic              i_flush,
    input  logic [INST_W-1:0] i_inst,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_jump,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_jump
);

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc;
    logic              r_jump;

    // Flush wins over capture so a redirect never leaves a stale entry behind.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_inst <= i_inst;
            r_pc   <= i_pc;
            r_jump <= i_jump;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_jump  = r_jump;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Desc     : Instruction fetch sequencer for a 1-cycle BRAM with stall skid
// Config   : FETCH_JALR_HOLD_EN - stop fetching after a consumed JALR until
//            the next redirect
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    input  logic              is_jump,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              w_issue;
    logic [PC_W-1:0]   r_pc;
    logic              r_rd_valid;
    logic [PC_W-1:0]   r_rd_pc;

    logic              w_skid_valid;
    logic [INST_W-1:0] w_skid_inst;
    logic [PC_W-1:0]   w_skid_pc;
    logic              w_skid_jump;
    logic              w_skid_capture;
    logic              w_skid_drain;

    logic              w_pres_valid;
    logic              w_pres_jump;
    logic              w_consume;
    logic              w_hold_trigger;

    assign w_pres_valid = w_skid_valid | r_rd_valid;
    assign inst_out     = w_skid_valid ? w_skid_inst : inst;
    assign inst_pc      = w_skid_valid ? w_skid_pc   : r_rd_pc;
    assign w_pres_jump  = w_skid_valid ? w_skid_jump : is_jump;
    assign inst_valid   = w_pres_valid & ~redirect_valid & (r_state == RUN);
    assign w_consume    = inst_valid & ~stall;
    assign pc           = r_pc;

`ifdef FETCH_JALR_HOLD_EN
    assign w_hold_trigger = w_consume & w_pres_jump;
`else
    logic w_unused_jump;
    assign w_hold_trigger = 1'b0;
    assign w_unused_jump  = w_pres_jump;
`endif

    // The response read in a stalled cycle is parked; the BRAM read issued
    // alongside it is dropped and re-issued once the stall clears.
    assign w_skid_capture = r_rd_valid & stall & ~w_skid_valid & ~redirect_valid;
    assign w_skid_drain   = w_skid_valid & ~stall;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_skid_capture),
        .i_drain   (w_skid_drain),
        .i_flush   (redirect_valid),
        .i_inst    (inst),
        .i_pc      (r_rd_pc),
        .i_jump    (is_jump),
        .o_valid   (w_skid_valid),
        .o_inst    (w_skid_inst),
        .o_pc      (w_skid_pc),
        .o_jump    (w_skid_jump)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_state_nxt = RUN;
                end else if (w_hold_trigger) begin
                    w_state_nxt = HOLD;
                end else if (!stall) begin
                    w_issue = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= RESET_PC;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Desc     : Directed scenarios plus random stall/redirect/reset traffic,
//            checked against a stream-level fetch model
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [7:0] RST_PC = 8'h10;
    localparam logic [6:0] JALR   = 7'b1100111;
`ifdef FETCH_JALR_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  pc;
    logic [31:0] inst;
    logic        is_jump;
    logic [31:0] inst_out;
    logic [7:0]  inst_pc;
    logic        inst_valid;

    logic [31:0] mem [256];
    logic [7:0]  bram_addr = 8'h00;

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .inst           (inst),
        .is_jump        (is_jump),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid)
    );

    always #5 clk = ~clk;

    // One-cycle read BRAM
    always @(posedge clk) bram_addr <= pc;
    assign inst    = mem[bram_addr];
    assign is_jump = (inst[6:0] == JALR);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Stream model: after reset/redirect to X the consumed stream is X, X+1, ...
    logic [7:0]  m_pc = RST_PC, m_next = RST_PC, p_pc = 8'h00;
    logic [31:0] p_inst = 32'h0;
    logic        m_hold = 1'b0, p_rst = 1'b1, p_issue = 1'b0, p_held = 1'b0;

    always @(negedge clk) begin : mon
        logic cons, trig, iss;
        if (p_rst) begin
            chk("rst_pc", pc, RST_PC);
            chk("rst_valid", inst_valid, 1'b0);
            chk("rst_int", {dut.r_rd_valid, dut.w_skid_valid}, 2'b00);
        end else begin
            chk("pc", pc, m_pc);
            chk("excl", dut.r_rd_valid & dut.w_skid_valid, 1'b0);
            if (redirect_valid)   chk("redir_valid", inst_valid, 1'b0);
            else if (m_hold)      chk("hold_valid", inst_valid, 1'b0);
            else if (p_issue)     chk("lat_valid", inst_valid, 1'b1);
            if (p_held && !redirect_valid)
                chk("stall_keep", {inst_valid, inst_pc, inst_out}, {1'b1, p_pc, p_inst});
        end
        cons = inst_valid && !stall;
        if (cons) begin
            chk("cons_pc", inst_pc, m_next);
            chk("cons_inst", inst_out, mem[m_next]);
        end
        trig   = HOLD_EN && cons && (mem[m_next][6:0] == JALR);
        iss    = !stall && !redirect_valid && !m_hold && !trig;
        p_held = inst_valid && stall && !redirect_valid && !rst;
        p_pc   = inst_pc;
        p_inst = inst_out;
        p_rst  = rst;
        if (rst) begin
            m_pc = RST_PC; m_next = RST_PC; m_hold = 1'b0; p_issue = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_next = redirect_pc; m_hold = 1'b0; p_issue = 1'b0;
        end else begin
            if (cons) m_next = m_next + 8'd1;
            if (trig) m_hold = 1'b1;
            p_issue = iss;
            if (iss) m_pc = m_pc + 8'd1;
        end
    end

    logic       s_valid;
    logic [7:0] s_ipc, s_pc;

    task automatic drv(input logic r, input logic s, input logic rv, input logic [7:0] rp);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        @(negedge clk);
        s_valid = inst_valid; s_ipc = inst_pc; s_pc = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       r, s, rv;
        logic [7:0] rp;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i][6:0] == JALR) mem[i][6:0] = 7'h13;
            if (i == 5 || (i % 16) == 9) mem[i][6:0] = JALR;
        end

        drv(1, 0, 0, 8'h00);
        drv(1, 0, 0, 8'h00);

        // Sequential start-up from RESET_PC
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 8'h00);
            chk("start_pc", s_pc, 8'(RST_PC + i));
            if (i == 0) begin
                chk("start_v0", s_valid, 1'b0);
            end else begin
                chk("start_ipc", {s_valid, s_ipc}, {1'b1, 8'(RST_PC + i - 1)});
            end
        end

        // Stall with 0x21 on the decode port
        drv(0, 0, 1, 8'h21);
        drv(0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 8'h00);
            chk("stall_21", {s_valid, s_ipc}, {1'b1, 8'h21});
        end
        drv(0, 0, 0, 8'h00);
        chk("release_21", {s_valid, s_ipc}, {1'b1, 8'h21});
        drv(0, 0, 0, 8'h00);
        chk("after_21", {s_valid, s_ipc}, {1'b1, 8'h22});

        // Redirect while stalled with a full skid
        drv(0, 1, 0, 8'h00);
        drv(0, 1, 1, 8'h40);
        chk("redir_cyc", s_valid, 1'b0);
        drv(0, 1, 0, 8'h00);
        chk("redir_next", s_valid, 1'b0);
        drv(0, 0, 0, 8'h00);
        chk("redir_bub", s_valid, 1'b0);
        drv(0, 0, 0, 8'h00);
        chk("redir_40", {s_valid, s_ipc}, {1'b1, 8'h40});

        // PC wrap
        drv(0, 0, 1, 8'hFF);
        drv(0, 0, 0, 8'h00);
        chk("wrap_pcff", s_pc, 8'hFF);
        drv(0, 0, 0, 8'h00);
        chk("wrap_pc00", {s_pc, s_valid, s_ipc}, {8'h00, 1'b1, 8'hFF});
        drv(0, 0, 0, 8'h00);
        chk("wrap_ipc00", {s_valid, s_ipc}, {1'b1, 8'h00});

        // JALR at word 0x05
        drv(0, 0, 1, 8'h05);
        drv(0, 0, 0, 8'h00);
        drv(0, 0, 0, 8'h00);
        chk("jalr_05", {s_valid, s_ipc}, {1'b1, 8'h05});
`ifdef FETCH_JALR_HOLD_EN
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 8'h00);
            chk("hold_quiet", {s_valid, s_pc}, {1'b0, 8'h06});
        end
        drv(0, 0, 1, 8'h30);
        chk("hold_redir", s_valid, 1'b0);
        drv(0, 0, 0, 8'h00);
        chk("hold_bub", s_valid, 1'b0);
        drv(0, 0, 0, 8'h00);
        chk("hold_30", {s_valid, s_ipc}, {1'b1, 8'h30});
`else
        drv(0, 0, 0, 8'h00);
        chk("nohold_06", {s_valid, s_ipc}, {1'b1, 8'h06});
`endif

        // Reset with a full skid, then reset out of a JALR stop
        drv(0, 0, 1, 8'h05);
        drv(0, 0, 0, 8'h00);
        drv(0, 1, 0, 8'h00);
        drv(0, 1, 0, 8'h00);
        drv(1, 1, 0, 8'h00);
        drv(0, 1, 0, 8'h00);
        chk("rst_skid", {s_valid, s_pc}, {1'b0, RST_PC});
        drv(0, 0, 1, 8'h05);
        drv(0, 0, 0, 8'h00);
        drv(0, 0, 0, 8'h00);
        drv(0, 0, 0, 8'h00);
        drv(1, 0, 1, 8'h77);
        drv(0, 1, 0, 8'h00);
        chk("rst_hold", {s_valid, s_pc}, {1'b0, RST_PC});

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 6);
            rp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            drv(r, s, rv, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
